csla_bec_pipe: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor. Each BLK-bit group computes one RCA
//  sum with carry-in 0 and derives the carry-in-1 result with a bec_n excess-1 converter.
//  A carry-select mux picks the result. The datapath is split into NSTG register stages with

---
 rtl/csla_bec_pipe_pkg.sv | 27 ++
 rtl/csla_bec_pipe_bec_n.sv | 13 +
 rtl/csla_bec_pipe.sv | 117 +++++++++++
 tb/tb_csla_bec_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/csla_bec_pipe_pkg.sv
// csla_pkg: shared sizing constants and the ripple-carry helper for the
// pipelined carry-select adder.
package csla_pkg;
    localparam int W_DEF = 32;
    localparam int BLK_DEF = 4;
    localparam int NSTG_DEF = 2;
    localparam int NGRP = W_DEF / BLK_DEF;
    localparam int GPS = NGRP / NSTG_DEF;
    localparam int MAXB = 32;

    // Returns {co, s} packed as bit n = carry-out, bits n-1:0 = sum.
    function automatic logic [MAXB:0] rca(input logic [MAXB-1:0] a, input logic [MAXB-1:0] b,
                                          input logic ci, input int n);
        logic [MAXB:0] r;
        logic c;
        r = '0;
        c = ci;
        for (int i = 0; i < MAXB; i++) begin
            if (i < n) begin
                r[i] = a[i] ^ b[i] ^ c;
                c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        r = r | ((MAXB + 1)'(c) << n);
        return r;
    endfunction
endpackage

// File: rtl/csla_bec_pipe_bec_n.sv
// bec_n: binary-to-excess-1 converter producing the carry-in-1 variant of a
// group sum from its carry-in-0 sum.
module bec_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign sum  = a + N'(1);
    assign cout = cin ^ (&a);
endmodule

// File: rtl/csla_bec_pipe.sv
// csla_bec_pipe: pipelined carry-select adder/subtractor; each stage resolves
// W/NSTG bits and hands its carry and the unprocessed operand bits onward.
module csla_bec_pipe
    import csla_pkg::*;
#(
    parameter int BLK  = BLK_DEF,
    parameter int W    = NGRP * BLK_DEF,
    parameter int NSTG = NGRP / GPS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int SW = W / NSTG;
    localparam int GS = SW / BLK;
    localparam int RW = W - SW;

    logic [NSTG-1:0]         rdy, v_q, c_q;
    logic [NSTG-1:0][W-1:0]  r_q;
    logic [NSTG-2:0][RW-1:0] a_q, b_q;
    logic [W-1:0]            b_x;
    logic                    m_q;

    assign b_x       = sub ? ~b : b;
    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSTG-1];
    assign sum       = r_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = m_q ^ c_q[NSTG-1];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [SW-1:0] xa, xb, s_d;
        logic [W-1:0]  rin, r_d;
        logic          cs, vi;
        // A stage may load when some stage at or after it is empty, or the sink drains.
        assign rdy[k] = out_ready | ~&v_q[NSTG-1:k];
        if (k == 0) begin : g_src
            assign xa  = a[SW-1:0];
            assign xb  = b_x[SW-1:0];
            assign cs  = sub | cin;
            assign rin = '0;
            assign vi  = in_valid;
        end else begin : g_src
            assign xa  = a_q[k-1][SW-1:0];
            assign xb  = b_q[k-1][SW-1:0];
            assign cs  = c_q[k-1];
            assign rin = r_q[k-1];
            assign vi  = v_q[k-1];
        end
        for (genvar g = 0; g < GS; g++) begin : g_grp
            logic ci, co;
            if (g == 0) begin : g_ci
                assign ci = cs;
            end else begin : g_ci
                assign ci = g_grp[g-1].co;
            end
            if (k == 0 && g == 0) begin : g_rca
                assign {co, s_d[BLK-1:0]} =
                    (BLK + 1)'(rca(MAXB'(xa[BLK-1:0]), MAXB'(xb[BLK-1:0]), ci, BLK));
            end else begin : g_csl
                logic [BLK-1:0] s0, s1;
                logic           c0, c1;
                assign {c0, s0} =
                    (BLK + 1)'(rca(MAXB'(xa[g*BLK +: BLK]), MAXB'(xb[g*BLK +: BLK]), 1'b0, BLK));
                bec_n #(.N(BLK)) u_bec (.a(s0), .cin(c0), .sum(s1), .cout(c1));
                assign {co, s_d[g*BLK +: BLK]} = ci ? {c1, s1} : {c0, s0};
            end
        end
        assign r_d = rin | (W'(s_d) << (k * SW));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                r_q[k] <= '0;
            end else if (rdy[k]) begin
                v_q[k] <= vi;
                c_q[k] <= g_grp[GS-1].co;
                r_q[k] <= r_d;
            end
        end
        if (k < NSTG - 1) begin : g_rem
            logic [RW-1:0] ra_d, rb_d;
            if (k == 0) begin : g_sh
                assign ra_d = a[W-1:SW];
                assign rb_d = b_x[W-1:SW];
            end else begin : g_sh
                assign ra_d = a_q[k-1] >> SW;
                assign rb_d = b_q[k-1] >> SW;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (rdy[k]) begin
                    a_q[k] <= ra_d;
                    b_q[k] <= rb_d;
                end
            end
        end else begin : g_msb
            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) m_q <= 1'b0;
                else if (rdy[k]) m_q <= s_d[SW-1] ^ xa[SW-1] ^ xb[SW-1];
            end
        end
    end
endmodule

// File: tb/tb_csla_bec_pipe.sv
// tb_csla_bec_pipe: scoreboard bench; expected results come from plain
// integer arithmetic on the accepted operands.
module tb_csla_bec_pipe;
    localparam int W = 32;
    localparam int NSTG = 2;

    logic         clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;
    int           total = 0, bad = 0, cyc = 0;
    logic [W+1:0] exq[$];
    int           pops[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csla_bec_pipe #(.BLK(4), .W(W), .NSTG(NSTG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Returns {cout, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        longint ux, uy, sx, sy, u, sr;
        logic co, ov;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            u  = ux - uy;
            sr = sx - sy;
            co = (ux >= uy);
        end else begin
            u  = ux + uy + longint'(c);
            sr = sx + sy + longint'(c);
            co = (u >= 64'sh1_0000_0000);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {co, ov, u[W-1:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) exq.delete();
        else begin
            if (in_valid && in_ready) exq.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                pops.push_back(cyc);
                if (exq.size() == 0) check("sb_empty", {cout, ovf, sum}, 64'hDEAD);
                else check("sb", {cout, ovf, sum}, exq.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs, input bit rbp);
        int n;
        n = 0;
        a = va;
        b = vb;
        cin = vc;
        sub = vs;
        in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 60) begin
                total++;
                bad++;
                $display("FAIL send_timeout in_ready=%0b", in_ready);
                break;
            end
            @(posedge clk);
            #1;
            if (rbp) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        if (rbp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic dir(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic vs, input logic [W-1:0] es,
                       input logic ec, input logic eo);
        int n;
        out_ready = 1;
        send(va, vb, vc, vs, 0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_lat"}, 64'(n), 64'(NSTG));
        check({nm, "_sum"}, sum, es);
        check({nm, "_flags"}, {cout, ovf}, {ec, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, n;
        logic [W+1:0] hs;
        bit hv;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_out", {cout, ovf, sum}, 0);
        check("rst_inready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        dir("t1", 32'hFFFF_FFFF, 0, 1, 0, 0, 1, 0);
        dir("t2", 32'h7FFF_FFFF, 1, 0, 0, 32'h8000_0000, 0, 1);
        dir("t3a", 5, 7, 1, 1, 32'hFFFF_FFFE, 0, 0);
        dir("t3b", 7, 5, 0, 1, 2, 1, 0);
        pops.delete();
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), 0);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_count", pops.size(), 8);
        if (pops.size() >= 8) check("b2b_span", 64'(pops[7] - pops[0]), 7);
        out_ready = 0;
        acc = 0;
        hv = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            if (out_valid) begin
                if (!hv) begin
                    hs = {cout, ovf, sum};
                    hv = 1;
                end else check("bp_hold", {cout, ovf, sum}, hs);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        check("bp_accepts", acc, NSTG);
        check("bp_inready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drain", exq.size(), 0);
        for (int i = 0; i < 150; i++) begin
            send(pick(), pick(), 1'($urandom), 1'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        out_ready = 1;
        n = 0;
        while (exq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rand_drain", exq.size(), 0);
        out_ready = 0;
        send($urandom, $urandom, 0, 0, 0);
        send($urandom, $urandom, 1, 1, 0);
        check("rf_full", out_valid, 1);
        #3;
        rst_n = 0;
        #1;
        check("rf_valid", out_valid, 0);
        check("rf_out", {cout, ovf, sum}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        check("rf_flush", exq.size(), 0);
        dir("rf_new", 32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0);
        check("end_empty", exq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
